// File: rtl/ccff_pkg.sv
// Shared types, CRC constant and bit-serial CRC step for the configuration-chain loader.
package ccff_pkg;

  localparam int unsigned CCFF_CRC_W = 8;
  localparam logic [CCFF_CRC_W-1:0] CCFF_CRC_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } ccff_state_t;

  // One MSB-first CRC-8 step absorbing a single serial bit.
  function automatic logic [CCFF_CRC_W-1:0] crc8_bit(input logic [CCFF_CRC_W-1:0] crc,
                                                     input logic din);
    logic fb;
    fb = crc[CCFF_CRC_W-1] ^ din;
    return {crc[CCFF_CRC_W-2:0], 1'b0} ^ (fb ? CCFF_CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word handshake between the bitstream source and the chain loader.
interface ccff_chain_loader_if #(
  parameter int unsigned WORD_W = 8
) ();

  logic [WORD_W-1:0] bs_data;
  logic              bs_valid;
  logic              bs_ready;

  modport master (output bs_data, output bs_valid, input bs_ready);
  modport slave  (input bs_data, input bs_valid, output bs_ready);

endinterface

// File: rtl/ccff_crc8_serial.sv
// Bit-serial CRC-8 accumulator with synchronous clear.
module ccff_crc8_serial
  import ccff_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic                  i_bit,
  output logic [CCFF_CRC_W-1:0] o_crc
);

  logic [CCFF_CRC_W-1:0] r_crc;

  // Clear takes priority over absorbing a bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= crc8_bit(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words LSB-first into a configuration chain, with optional
// recirculating CRC verify pass over the chain tail.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 31,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                   prog_clk,
  input  logic                   prog_reset,
  input  logic                   start,
  input  logic                   verify_en,
  ccff_chain_loader_if.slave     bs,
  input  logic                   ccff_tail,
  output logic                   ccff_head,
  output logic                   chain_shift_en,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [CNT_W-1:0]       bit_count
);

  localparam int unsigned BCNT_W = $clog2(WORD_W + 1);

  ccff_state_t             r_state, w_next_state;
  logic [WORD_W-1:0]       r_buf, w_buf;
  logic [BCNT_W-1:0]       r_buf_cnt, w_buf_cnt;
  logic [CNT_W-1:0]        r_bit_count, w_bit_count;
  logic                    r_verify, w_verify;
  logic                    w_shift, w_head, w_ready, w_last;
  logic                    w_crc_clr, w_lcrc_en, w_vcrc_en;
  logic [CCFF_CRC_W-1:0]   w_lcrc, w_vcrc;

  // State register.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) r_state <= ST_IDLE;
    else            r_state <= w_next_state;
  end

  // Word buffer, pass bit counter and latched verify request.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_buf       <= '0;
      r_buf_cnt   <= '0;
      r_bit_count <= '0;
      r_verify    <= 1'b0;
    end else begin
      r_buf       <= w_buf;
      r_buf_cnt   <= w_buf_cnt;
      r_bit_count <= w_bit_count;
      r_verify    <= w_verify;
    end
  end

  // Next-state, shift control and buffer refill.
  always_comb begin
    w_next_state = r_state;
    w_buf        = r_buf;
    w_buf_cnt    = r_buf_cnt;
    w_bit_count  = r_bit_count;
    w_verify     = r_verify;
    w_shift      = 1'b0;
    w_head       = 1'b0;
    w_ready      = 1'b0;
    w_crc_clr    = 1'b0;
    w_lcrc_en    = 1'b0;
    w_vcrc_en    = 1'b0;
    w_last       = (r_bit_count == CNT_W'(CHAIN_LEN - 1));
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          w_next_state = ST_LOAD;
          w_buf        = '0;
          w_buf_cnt    = '0;
          w_bit_count  = '0;
          w_verify     = verify_en;
          w_crc_clr    = 1'b1;
        end
      end
      ST_LOAD: begin
        // A non-empty buffer always shifts, so a single remaining bit frees the buffer.
        w_ready = (r_buf_cnt == '0) || (r_buf_cnt == BCNT_W'(1));
        if (r_buf_cnt != '0) begin
          w_shift     = 1'b1;
          w_head      = r_buf[0];
          w_lcrc_en   = 1'b1;
          w_bit_count = r_bit_count + CNT_W'(1);
          w_buf       = r_buf >> 1;
          w_buf_cnt   = r_buf_cnt - BCNT_W'(1);
        end
        if (w_ready && bs.bs_valid) begin
          w_buf     = bs.bs_data;
          w_buf_cnt = BCNT_W'(WORD_W);
        end
        // Chain full: drop any leftover bits of the final word.
        if (w_shift && w_last) begin
          w_buf     = '0;
          w_buf_cnt = '0;
          if (r_verify) begin
            w_next_state = ST_VERIFY;
            w_bit_count  = '0;
          end else begin
            w_next_state = ST_DONE;
          end
        end
      end
      ST_VERIFY: begin
        // Tail feeds head so the configuration survives the verify pass.
        w_shift     = 1'b1;
        w_head      = ccff_tail;
        w_vcrc_en   = 1'b1;
        w_bit_count = r_bit_count + CNT_W'(1);
        if (w_last) begin
          w_next_state = (crc8_bit(w_vcrc, ccff_tail) == w_lcrc) ? ST_DONE : ST_ERROR;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  ccff_crc8_serial u_load_crc (
    .clk   (prog_clk),
    .rst   (prog_reset),
    .i_en  (w_lcrc_en),
    .i_clr (w_crc_clr),
    .i_bit (w_head),
    .o_crc (w_lcrc)
  );

  ccff_crc8_serial u_verify_crc (
    .clk   (prog_clk),
    .rst   (prog_reset),
    .i_en  (w_vcrc_en),
    .i_clr (w_crc_clr),
    .i_bit (ccff_tail),
    .o_crc (w_vcrc)
  );

  assign bs.bs_ready     = w_ready;
  assign ccff_head       = w_head;
  assign chain_shift_en  = w_shift;
  assign busy            = (r_state == ST_LOAD) || (r_state == ST_VERIFY);
  assign done            = (r_state == ST_DONE);
  assign error           = (r_state == ST_ERROR);
  assign bit_count       = r_bit_count;

endmodule
